stdp_update_scheduler: RTL and testbench

//  Detects pre/post spike pairings for NUM_PRE synapses and queues one pending

---
 rtl/stdp_update_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_stdp_update_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_update_scheduler.sv
// STDP pairing detector with per-synapse update queue, sharing one
// weight read-modify-write engine between synapses via a round-robin arbiter.
module stdp_update_scheduler #(
    parameter int NUM_PRE   = 5,
    parameter int TW        = 8,
    parameter int WW        = 8,
    parameter int T_WIN     = 32,
    parameter int LTP_SHIFT = 2,
    parameter int LTD_SHIFT = 2,
    localparam int AW       = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_PRE-1:0] pre_spike,
    input  logic               post_spike,
    output logic               mem_req,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [WW-1:0]      mem_wdata,
    input  logic [WW-1:0]      mem_rdata,
    input  logic               mem_ack,
    output logic               busy,
    output logic [NUM_PRE-1:0] pending,
    output logic               upd_done,
    output logic [AW-1:0]      upd_idx,
    output logic [WW-1:0]      upd_weight
);
    localparam int DW = TW + 1;
    localparam int SW = ((WW > DW) ? WW : DW) + 1;
    localparam logic [TW-1:0] TWIN_T = TW'(T_WIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CALC = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_pre_t [NUM_PRE];
    logic [TW-1:0]       r_post_t;
    logic [NUM_PRE-1:0]  r_pend;
    logic                r_q_pol [NUM_PRE];
    logic [TW-1:0]       r_q_dt  [NUM_PRE];
    logic [NUM_PRE-1:0]  w_cap;
    logic                w_cap_pol [NUM_PRE];
    logic [TW-1:0]       w_cap_dt  [NUM_PRE];
    logic [AW-1:0]       r_rr;
    logic [AW-1:0]       r_idx;
    logic                r_pol;
    logic [TW-1:0]       r_dt;
    logic [WW-1:0]       r_rdata;
    logic [WW-1:0]       r_wdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic                r_busy;
    logic                w_grant;
    logic                w_hi_found;
    logic [AW-1:0]       w_hi_idx;
    logic [AW-1:0]       w_lo_idx;
    logic [AW-1:0]       w_grant_idx;
    logic [DW-1:0]       w_span;
    logic [DW-1:0]       w_delta;
    logic [SW-1:0]       w_sum;
    logic [WW-1:0]       w_new;

    // Spike timers: load 1 on a spike, otherwise count up and saturate
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PRE; i++) begin
            if (!rst_n)
                r_pre_t[i] <= {TW{1'b1}};
            else if (pre_spike[i])
                r_pre_t[i] <= TW'(1);
            else if (r_pre_t[i] != {TW{1'b1}})
                r_pre_t[i] <= r_pre_t[i] + TW'(1);
            else
                r_pre_t[i] <= r_pre_t[i];
        end
        if (!rst_n)
            r_post_t <= {TW{1'b1}};
        else if (post_spike)
            r_post_t <= TW'(1);
        else if (r_post_t != {TW{1'b1}})
            r_post_t <= r_post_t + TW'(1);
        else
            r_post_t <= r_post_t;
    end

    // Pairing detection; a coincident pre/post spike is pure LTP with dt=0
    always_comb begin
        for (int i = 0; i < NUM_PRE; i++) begin
            w_cap[i]     = 1'b0;
            w_cap_pol[i] = 1'b0;
            w_cap_dt[i]  = {TW{1'b0}};
            if (en && pre_spike[i] && post_spike) begin
                w_cap[i]     = 1'b1;
                w_cap_pol[i] = 1'b1;
            end else if (en && post_spike && (r_pre_t[i] < TWIN_T)) begin
                w_cap[i]     = 1'b1;
                w_cap_pol[i] = 1'b1;
                w_cap_dt[i]  = r_pre_t[i];
            end else if (en && pre_spike[i] && (r_post_t < TWIN_T)) begin
                w_cap[i]     = 1'b1;
                w_cap_dt[i]  = r_post_t;
            end else begin
                w_cap[i]     = 1'b0;
            end
        end
    end

    // Round-robin search: lowest pending index above rr, else lowest overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = {AW{1'b0}};
        w_lo_idx   = {AW{1'b0}};
        for (int i = NUM_PRE - 1; i >= 0; i--) begin
            w_hi_found = w_hi_found | (r_pend[i] & (AW'(i) > r_rr));
            w_hi_idx   = (r_pend[i] && (AW'(i) > r_rr)) ? AW'(i) : w_hi_idx;
            w_lo_idx   = r_pend[i] ? AW'(i) : w_lo_idx;
        end
        w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        w_grant     = (r_state == S_IDLE) && (|r_pend);
    end

    // Pending bits and queued polarity/dt; a fresh capture beats the grant clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PRE; i++) begin
            if (!rst_n) begin
                r_pend[i]  <= 1'b0;
                r_q_pol[i] <= 1'b0;
                r_q_dt[i]  <= {TW{1'b0}};
            end else if (w_cap[i]) begin
                r_pend[i]  <= 1'b1;
                r_q_pol[i] <= w_cap_pol[i];
                r_q_dt[i]  <= w_cap_dt[i];
            end else if (w_grant && (w_grant_idx == AW'(i))) begin
                r_pend[i]  <= 1'b0;
            end else begin
                r_pend[i]  <= r_pend[i];
            end
        end
    end

    // Next-state logic of the read-modify-write engine
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_grant ? S_RD : S_IDLE;
            S_RD:    w_state_nxt = mem_ack ? S_CALC : S_RD;
            S_CALC:  w_state_nxt = S_WR;
            S_WR:    w_state_nxt = mem_ack ? S_IDLE : S_WR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Weight arithmetic with saturation on LTP and floor at zero on LTD
    always_comb begin
        w_span  = DW'(T_WIN) - {1'b0, r_dt};
        w_delta = r_pol ? (w_span >> LTP_SHIFT) : (w_span >> LTD_SHIFT);
        w_sum   = SW'(r_rdata) + SW'(w_delta);
        if (r_pol)
            w_new = (|w_sum[SW-1:WW]) ? {WW{1'b1}} : w_sum[WW-1:0];
        else if (SW'(w_delta) > SW'(r_rdata))
            w_new = {WW{1'b0}};
        else
            w_new = r_rdata - WW'(w_delta);
    end

    // State register, grant latch, data path and registered memory controls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr      <= AW'(NUM_PRE - 1);
            r_idx     <= {AW{1'b0}};
            r_pol     <= 1'b0;
            r_dt      <= {TW{1'b0}};
            r_rdata   <= {WW{1'b0}};
            r_wdata   <= {WW{1'b0}};
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
            r_mem_we  <= (w_state_nxt == S_WR);
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_idx <= w_grant_idx;
                r_pol <= r_q_pol[w_grant_idx];
                r_dt  <= r_q_dt[w_grant_idx];
                r_rr  <= w_grant_idx;
            end else begin
                r_idx <= r_idx;
            end
            if ((r_state == S_RD) && mem_ack)
                r_rdata <= mem_rdata;
            else
                r_rdata <= r_rdata;
            if (r_state == S_CALC)
                r_wdata <= w_new;
            else
                r_wdata <= r_wdata;
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_idx;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign pending    = r_pend;
    assign upd_done   = (r_state == S_WR) && mem_ack;
    assign upd_idx    = r_idx;
    assign upd_weight = r_wdata;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler with a small weight memory model
// and hand-computed expected weights.
module tb_stdp_update_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [4:0] pre_spike = 5'd0;
    logic       post_spike = 1'b0;
    logic       mem_req, mem_we, mem_ack;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       busy, upd_done;
    logic [4:0] pending;
    logic [2:0] upd_idx;
    logic [7:0] upd_weight;

    logic [7:0] mem [8];
    logic       pl_we = 1'b0;
    logic [2:0] pl_addr = 3'd0;
    logic [7:0] pl_data = 8'd0;
    logic       wr_ack_on = 1'b1;
    logic       force_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cnt = 0;
    int upd_idx_q[$];
    int upd_w_q[$];
    int upd_cyc_q[$];

    stdp_update_scheduler dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike),
        .post_spike(post_spike), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .pending(pending),
        .upd_done(upd_done), .upd_idx(upd_idx), .upd_weight(upd_weight)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = force_ack | (mem_req & (mem_we ? wr_ack_on : 1'b1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (mem_req && mem_we && mem_ack)
            mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_req)
            req_cnt <= req_cnt + 1;
        if (upd_done) begin
            upd_idx_q.push_back(int'(upd_idx));
            upd_w_q.push_back(int'(upd_weight));
            upd_cyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        step();
        pl_we   = 1'b0;
    endtask

    task automatic wait_upd(input int n, input int budget, input string tag);
        int k = 0;
        while (upd_idx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        step();
        check_eq(tag, upd_idx_q.size(), n);
    endtask

    initial begin
        int base;
        int req0;
        int k;
        for (int i = 0; i < 8; i++) begin
            pl_addr = 3'(i);
            pl_data = 8'd0;
            pl_we   = 1'b1;
            @(posedge clk);
            #1;
        end
        pl_we = 1'b0;
        do_reset();
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pend", pending, 0);
        check_eq("rst_done", upd_done, 0);

        // 1: pre at 0, post at 10 -> LTP dt=10, delta=5
        preload(3'd0, 8'd100);
        base = upd_idx_q.size();
        pre_spike = 5'b00001; step(); pre_spike = 5'd0;
        repeat (9) step();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        check_eq("t1_pend", pending, 5'b00001);
        wait_upd(base + 1, 20, "t1_cnt");
        check_eq("t1_idx", upd_idx_q[base], 0);
        check_eq("t1_w", upd_w_q[base], 105);
        check_eq("t1_mem", mem[0], 105);
        repeat (40) step();

        // 2: post at 0, pre[2] at 4 -> LTD dt=4, delta=7, clamps at 0
        preload(3'd2, 8'd3);
        base = upd_idx_q.size();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        repeat (3) step();
        pre_spike = 5'b00100; step(); pre_spike = 5'd0;
        check_eq("t2_pend", pending, 5'b00100);
        wait_upd(base + 1, 20, "t2_cnt");
        check_eq("t2_idx", upd_idx_q[base], 2);
        check_eq("t2_w", upd_w_q[base], 0);
        check_eq("t2_mem", mem[2], 0);
        repeat (40) step();

        // 3: coincident pre[1]/post -> LTP dt=0, delta=8, saturates
        preload(3'd1, 8'd250);
        base = upd_idx_q.size();
        pre_spike = 5'b00010; post_spike = 1'b1; step();
        pre_spike = 5'd0; post_spike = 1'b0;
        wait_upd(base + 1, 20, "t3_cnt");
        check_eq("t3_idx", upd_idx_q[base], 1);
        check_eq("t3_w", upd_w_q[base], 255);
        check_eq("t3_mem", mem[1], 255);
        repeat (40) step();

        // en=0 blocks capture
        en = 1'b0;
        pre_spike = 5'b00001; post_spike = 1'b1; step();
        pre_spike = 5'd0; post_spike = 1'b0;
        check_eq("en0_pend", pending, 0);
        step();
        check_eq("en0_busy", busy, 0);
        en = 1'b1;
        repeat (40) step();

        // 4: five LTP updates dt=1, delta=7, granted 0..4 every 4 cycles
        do_reset();
        for (int i = 0; i < 5; i++) preload(3'(i), 8'(10 * (i + 1)));
        base = upd_idx_q.size();
        pre_spike = 5'h1F; step(); pre_spike = 5'd0;
        post_spike = 1'b1; step(); post_spike = 1'b0;
        check_eq("t4_pend", pending, 5'h1F);
        wait_upd(base + 5, 60, "t4_cnt");
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t4_idx%0d", i), upd_idx_q[base + i], i);
            check_eq($sformatf("t4_w%0d", i), upd_w_q[base + i], 10 * (i + 1) + 7);
            if (i > 0)
                check_eq($sformatf("t4_gap%0d", i), upd_cyc_q[base + i] - upd_cyc_q[base + i - 1], 4);
        end
        check_eq("t4_mem4", mem[4], 57);
        repeat (40) step();

        // 5: post after reset, and dt=40 outside the window -> nothing queued
        do_reset();
        req0 = req_cnt;
        post_spike = 1'b1; step(); post_spike = 1'b0;
        check_eq("t5_pend_a", pending, 0);
        repeat (40) step();
        pre_spike = 5'b00001; step(); pre_spike = 5'd0;
        repeat (39) step();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        check_eq("t5_pend_b", pending, 0);
        repeat (5) step();
        check_eq("t5_req", req_cnt - req0, 0);
        check_eq("t5_busy", busy, 0);
        repeat (40) step();

        // 6: reset while WR waits for ack; late ack ignored
        do_reset();
        preload(3'd1, 8'd60);
        preload(3'd3, 8'd70);
        wr_ack_on = 1'b0;
        base = upd_idx_q.size();
        pre_spike = 5'b01010; post_spike = 1'b1; step();
        pre_spike = 5'd0; post_spike = 1'b0;
        k = 0;
        while (!(mem_req && mem_we) && k < 20) begin
            step();
            k++;
        end
        check_eq("t6_in_wr", mem_req && mem_we, 1);
        check_eq("t6_addr", mem_addr, 1);
        check_eq("t6_pend_wr", pending, 5'b01000);
        rst_n = 1'b0; step();
        check_eq("t6_req", mem_req, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_pend", pending, 0);
        rst_n = 1'b1;
        wr_ack_on = 1'b1;
        force_ack = 1'b1;
        repeat (3) step();
        force_ack = 1'b0;
        step();
        check_eq("t6_nodone", upd_idx_q.size(), base);
        check_eq("t6_idle", busy, 0);
        check_eq("t6_mem1", mem[1], 60);
        check_eq("t6_mem3", mem[3], 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
